writeburst_avalon_master: RTL and testbench

- Responder end of the writeburst link. Accepts a held writeburst request (address, dword count, two byteenables, 56-bit byte-packed data) and performs it as one Avalon-MM write burst of 1 or 2 beats.
- Returns a one-cycle done pulse when the last beat is accepted.
- Sits between the writeburst link output and the memory-side Avalon master port.

---
 rtl/writeburst_avalon_master.sv | 97 +++++++++
 tb/tb_writeburst_avalon_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeburst_avalon_master.sv
// Writeburst responder: turns one held writeburst request into a 1- or 2-beat
// Avalon-MM write burst and pulses writeburst_done once the last beat is taken.
module writeburst_avalon_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        writeburst_do,
  output logic        writeburst_done,
  input  logic [31:0] writeburst_address,
  input  logic [1:0]  writeburst_dword_length,
  input  logic [3:0]  writeburst_byteenable_0,
  input  logic [3:0]  writeburst_byteenable_1,
  input  logic [55:0] writeburst_data,
  output logic [29:0] avm_address,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  output logic [1:0]  avm_burstcount,
  output logic        avm_write,
  input  logic        avm_waitrequest
);

  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, DONE, RELEASE} state_t;

  state_t      state, state_next;
  logic [31:0] dword1_q;
  logic [3:0]  be1_q;
  logic [1:0]  len_q;
  logic [63:0] shifted;
  logic [1:0]  req_len;
  logic        accept;
  logic        capture;

  // Data lands on byte lanes starting at the address byte offset.
  assign shifted = {8'd0, writeburst_data} << {writeburst_address[1:0], 3'b000};
  assign accept  = avm_write & ~avm_waitrequest;
  assign capture = (state == IDLE) & writeburst_do;

  // Clamp the requested dword count into the legal burst range 1..2.
  always_comb begin
    case (writeburst_dword_length)
      2'd0:    req_len = 2'd1;
      2'd3:    req_len = 2'd2;
      default: req_len = writeburst_dword_length;
    endcase
  end

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (writeburst_do) state_next = BEAT0;
      BEAT0:   if (accept) state_next = (len_q == 2'd2) ? BEAT1 : DONE;
      BEAT1:   if (accept) state_next = DONE;
      DONE:    state_next = RELEASE;
      RELEASE: if (!writeburst_do) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Registered Avalon outputs, done pulse and captured second-beat data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avm_address     <= '0;
      avm_writedata   <= '0;
      avm_byteenable  <= '0;
      avm_burstcount  <= '0;
      avm_write       <= 1'b0;
      writeburst_done <= 1'b0;
      dword1_q        <= '0;
      be1_q           <= '0;
      len_q           <= '0;
    end else begin
      // Strobes follow the state being entered so they are glitch-free registers.
      avm_write       <= (state_next == BEAT0) || (state_next == BEAT1);
      writeburst_done <= (state_next == DONE);
      if (capture) begin
        avm_address    <= writeburst_address[31:2];
        avm_burstcount <= req_len;
        avm_writedata  <= shifted[31:0];
        avm_byteenable <= writeburst_byteenable_0;
        dword1_q       <= shifted[63:32];
        be1_q          <= writeburst_byteenable_1;
        len_q          <= req_len;
      end else if ((state == BEAT0) && accept && (len_q == 2'd2)) begin
        // Address and burstcount stay put for the second beat of the burst.
        avm_writedata  <= dword1_q;
        avm_byteenable <= be1_q;
      end
    end
  end

endmodule

// File: tb/tb_writeburst_avalon_master.sv
// Self-checking bench for writeburst_avalon_master with a byte-level reference model.
module tb_writeburst_avalon_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        writeburst_do = 1'b0;
  logic        writeburst_done;
  logic [31:0] writeburst_address = '0;
  logic [1:0]  writeburst_dword_length = '0;
  logic [3:0]  writeburst_byteenable_0 = '0;
  logic [3:0]  writeburst_byteenable_1 = '0;
  logic [55:0] writeburst_data = '0;
  logic [29:0] avm_address;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [1:0]  avm_burstcount;
  logic        avm_write;
  logic        avm_waitrequest = 1'b0;

  int passed = 0;
  int total  = 0;

  writeburst_avalon_master dut (
    .clk                     (clk),
    .rst                     (rst),
    .writeburst_do           (writeburst_do),
    .writeburst_done         (writeburst_done),
    .writeburst_address      (writeburst_address),
    .writeburst_dword_length (writeburst_dword_length),
    .writeburst_byteenable_0 (writeburst_byteenable_0),
    .writeburst_byteenable_1 (writeburst_byteenable_1),
    .writeburst_data         (writeburst_data),
    .avm_address             (avm_address),
    .avm_writedata           (avm_writedata),
    .avm_byteenable          (avm_byteenable),
    .avm_burstcount          (avm_burstcount),
    .avm_write               (avm_write),
    .avm_waitrequest         (avm_waitrequest)
  );

  always #5 clk = ~clk;

  function automatic logic [55:0] rand56();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[55:0];
  endfunction

  // Issue one request, play the slave with the given stall counts, and compare
  // every cycle against the model. hold_after = cycles do stays high after done.
  task automatic run_burst(input string name, input logic [31:0] addr,
                           input logic [1:0] dl, input logic [3:0] be0,
                           input logic [3:0] be1, input logic [55:0] data,
                           input int unsigned st0, input int unsigned st1,
                           input int unsigned hold_after);
    logic [7:0]  bytes [8];
    logic [31:0] exp_wd [2];
    logic [3:0]  exp_be [2];
    int unsigned nbeats, beat, stall_left, exp_done_cyc, dones, accepts;
    logic        in_burst;

    for (int i = 0; i < 8; i++) bytes[i] = 8'h00;
    for (int i = 0; i < 7; i++)
      if (int'(addr[1:0]) + i < 8) bytes[int'(addr[1:0]) + i] = data[8*i +: 8];
    exp_wd[0] = {bytes[3], bytes[2], bytes[1], bytes[0]};
    exp_wd[1] = {bytes[7], bytes[6], bytes[5], bytes[4]};
    exp_be[0] = be0;
    exp_be[1] = be1;
    nbeats = (dl == 2'd0) ? 1 : (dl == 2'd3) ? 2 : int'(dl);
    exp_done_cyc = 1 + nbeats + st0 + ((nbeats == 2) ? st1 : 0);

    @(posedge clk); #1;
    writeburst_do           = 1'b1;
    writeburst_address      = addr;
    writeburst_dword_length = dl;
    writeburst_byteenable_0 = be0;
    writeburst_byteenable_1 = be1;
    writeburst_data         = data;
    avm_waitrequest         = 1'b0;
    beat = 0; stall_left = st0; dones = 0; accepts = 0;
    @(posedge clk); #1;
    // Request fields must be ignored once captured.
    writeburst_address      = $urandom;
    writeburst_dword_length = 2'($urandom);
    writeburst_byteenable_0 = 4'($urandom);
    writeburst_byteenable_1 = 4'($urandom);
    writeburst_data         = rand56();

    for (int unsigned cyc = 1; cyc <= exp_done_cyc + hold_after + 1; cyc++) begin
      @(negedge clk);
      in_burst = (beat < nbeats);
      total++;
      if (avm_write !== in_burst) $display("FAIL %s write cyc%0d: got %b want %b", name, cyc, avm_write, in_burst);
      else passed++;
      if (in_burst) begin
        total++;
        if (avm_address !== addr[31:2] || avm_burstcount !== 2'(nbeats))
          $display("FAIL %s addr/burst cyc%0d: got %h/%0d want %h/%0d", name, cyc, avm_address, avm_burstcount, addr[31:2], nbeats);
        else passed++;
        total++;
        if (avm_writedata !== exp_wd[beat] || avm_byteenable !== exp_be[beat])
          $display("FAIL %s data/be beat%0d cyc%0d: got %h/%h want %h/%h", name, beat, cyc, avm_writedata, avm_byteenable, exp_wd[beat], exp_be[beat]);
        else passed++;
      end
      total++;
      if (writeburst_done !== (cyc == exp_done_cyc))
        $display("FAIL %s done cyc%0d: got %b want %b", name, cyc, writeburst_done, (cyc == exp_done_cyc));
      else passed++;
      if (writeburst_done === 1'b1) dones++;
      // Slave response for the edge closing this cycle.
      if (in_burst) begin
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          avm_waitrequest = 1'b0;
          if (avm_write === 1'b1) accepts++;
          beat++;
          if (beat == 1) stall_left = st1;
        end
      end else begin
        avm_waitrequest = 1'($urandom);
      end
      if (cyc == exp_done_cyc + hold_after) writeburst_do = 1'b0;
    end
    total++;
    if (dones != 1 || accepts != nbeats)
      $display("FAIL %s counts: got done=%0d accepts=%0d want done=1 accepts=%0d", name, dones, accepts, nbeats);
    else passed++;
    avm_waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({avm_address, avm_writedata, avm_byteenable, avm_burstcount, avm_write, writeburst_done} !== '0)
      $display("FAIL reset outputs: got %h %h %h %h %b %b want all zero", avm_address, avm_writedata, avm_byteenable, avm_burstcount, avm_write, writeburst_done);
    else passed++;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (avm_write !== 1'b0 || writeburst_done !== 1'b0)
        $display("FAIL reset idle: got write=%b done=%b want 0 0", avm_write, writeburst_done);
      else passed++;
    end
  endtask

  task automatic test_aligned_single();
    logic [55:0] d;
    d = rand56();
    d[31:0] = 32'hDDCCBBAA;
    run_burst("aligned_single", 32'h0000_2000, 2'd1, 4'hF, 4'h0, d, 0, 0, 0);
  endtask

  task automatic test_misaligned_double();
    run_burst("misaligned_double", 32'h0000_1003, 2'd2, 4'b1000, 4'b0001, 56'h0000_0000_00BB_AA, 0, 0, 0);
  endtask

  task automatic test_stall();
    run_burst("stall", 32'h0000_1003, 2'd2, 4'b1000, 4'b0001, 56'h0000_0000_00BB_AA, 3, 2, 0);
  endtask

  task automatic test_held_request();
    run_burst("held_first", 32'h0000_2000, 2'd1, 4'hF, 4'h0, rand56(), 0, 0, 4);
    run_burst("held_second", 32'h0000_3000, 2'd2, 4'h3, 4'hC, rand56(), 0, 1, 0);
  endtask

  task automatic test_length_edge();
    run_burst("len0", 32'h0000_4001, 2'd0, 4'hE, 4'h1, rand56(), 1, 0, 0);
    run_burst("len3", 32'h0000_4002, 2'd3, 4'hC, 4'h0, rand56(), 0, 2, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_burst("random", $urandom, 2'($urandom), 4'($urandom), 4'($urandom), rand56(),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
  endtask

  task automatic test_reset_mid_burst();
    @(posedge clk); #1;
    writeburst_do           = 1'b1;
    writeburst_address      = 32'h0000_5000;
    writeburst_dword_length = 2'd2;
    writeburst_byteenable_0 = 4'hF;
    writeburst_byteenable_1 = 4'hF;
    writeburst_data         = rand56();
    avm_waitrequest         = 1'b0;
    @(posedge clk);               // capture edge
    @(negedge clk);               // beat 0, accepted at the next edge
    avm_waitrequest = 1'b0;
    @(negedge clk);               // beat 1, stall it
    total++;
    if (avm_write !== 1'b1) $display("FAIL rst_mid beat1 write: got %b want 1", avm_write);
    else passed++;
    avm_waitrequest = 1'b1;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (avm_write !== 1'b0 || writeburst_done !== 1'b0 || avm_address !== '0)
      $display("FAIL rst_mid async: got write=%b done=%b addr=%h want 0 0 0", avm_write, writeburst_done, avm_address);
    else passed++;
    writeburst_do = 1'b0;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      total++;
      if (avm_write !== 1'b0 || writeburst_done !== 1'b0)
        $display("FAIL rst_mid idle: got write=%b done=%b want 0 0", avm_write, writeburst_done);
      else passed++;
    end
    run_burst("after_reset", 32'h0000_6002, 2'd2, 4'hC, 4'h3, rand56(), 1, 1, 0);
  endtask

  initial begin
    test_reset();
    test_aligned_single();
    test_misaligned_double();
    test_stall();
    test_held_request();
    test_length_edge();
    test_random();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
